// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared definitions for the multicycle MULT/DIV unit.
// Holds the FSM state encoding (also used by the control unit for its
// MULT/DIV wait states) and the default datapath/counter widths.
package mult_div_unit_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MULT_RUN = 2'd1,
    ST_DIV_RUN  = 2'd2,
    ST_DONE     = 2'd3
  } md_state_t;

endpackage

// File: rtl/div_restoring_step.sv
// div_restoring_step: one combinational iteration of unsigned restoring division.
// Ports:
//   rem_in   partial remainder (always < divisor, so fits WIDTH bits)
//   quot_in  dividend bits still to be shifted in / quotient bits shifted out
//   divisor  divisor magnitude
//   rem_out  partial remainder after shift and trial subtract
//   quot_out quot_in shifted left with the new quotient bit in bit 0
module div_restoring_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quot_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quot_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_in, quot_in[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_out  = diff[WIDTH-1:0];
      quot_out = {quot_in[WIDTH-2:0], 1'b1};
    end else begin
      // Restore: the shifted value is below the divisor, so its top bit is 0.
      rem_out  = shifted[WIDTH-1:0];
      quot_out = {quot_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed MULT (radix-2 Booth) / DIV (restoring on
// magnitudes) for the MIPS datapath; one iteration per clock, result in HI/LO.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   mult_start/div_start start requests, sampled only in IDLE (MULT wins)
//   a_in, b_in           operands, latched when a start is accepted
//   hi, lo               MULT: product high/low; DIV: remainder/quotient
//   busy                 operation in progress
//   done                 one-cycle completion pulse
//   div_zero             last DIV request had a zero divisor
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned CNT_W = MD_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  md_state_t        state, state_next;
  logic [CNT_W-1:0] cnt;
  // Shared datapath: MULT uses {acc,qr,q_m1} as Booth {P,Q,q-1} with opa the
  // multiplicand; DIV uses acc as remainder, qr as dividend/quotient, opa as divisor.
  logic [WIDTH-1:0] opa, acc, qr;
  logic             q_m1, quot_neg, rem_neg;

  logic accept_mult, accept_div, div_by_zero, finish, last_iter;

  logic [WIDTH:0]   p_ext, m_ext, b_sum;
  logic [WIDTH-1:0] booth_p, booth_q;
  logic [WIDTH-1:0] div_r, div_q, r_fix, q_fix;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_next  = state;
    accept_mult = 1'b0;
    accept_div  = 1'b0;
    div_by_zero = 1'b0;
    finish      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mult_start) begin
          accept_mult = 1'b1;
          state_next  = ST_MULT_RUN;
        end else if (div_start) begin
          if (b_in != '0) begin
            accept_div = 1'b1;
            state_next = ST_DIV_RUN;
          end else begin
            div_by_zero = 1'b1;
          end
        end
      end
      ST_MULT_RUN, ST_DIV_RUN: begin
        if (last_iter) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Booth step; the add/sub is one bit wider so negating the most negative
  // multiplicand cannot overflow before the arithmetic shift.
  always_comb begin
    p_ext = {acc[WIDTH-1], acc};
    m_ext = {opa[WIDTH-1], opa};
    case ({qr[0], q_m1})
      2'b01:   b_sum = p_ext + m_ext;
      2'b10:   b_sum = p_ext - m_ext;
      default: b_sum = p_ext;
    endcase
    booth_p = b_sum[WIDTH:1];
    booth_q = {b_sum[0], qr[WIDTH-1:1]};
  end

  div_restoring_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (acc),
    .quot_in (qr),
    .divisor (opa),
    .rem_out (div_r),
    .quot_out(div_q)
  );

  always_comb begin
    a_mag = a_in[WIDTH-1] ? ('0 - a_in) : a_in;
    b_mag = b_in[WIDTH-1] ? ('0 - b_in) : b_in;
    q_fix = quot_neg ? ('0 - div_q) : div_q;
    r_fix = rem_neg  ? ('0 - div_r) : div_r;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      opa      <= '0;
      acc      <= '0;
      qr       <= '0;
      q_m1     <= 1'b0;
      quot_neg <= 1'b0;
      rem_neg  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;

      if (accept_mult || accept_div) begin
        busy     <= 1'b1;
        cnt      <= '0;
        div_zero <= 1'b0;
        opa      <= accept_mult ? a_in : b_mag;
        acc      <= '0;
        qr       <= accept_mult ? b_in : a_mag;
        q_m1     <= 1'b0;
        quot_neg <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
        rem_neg  <= a_in[WIDTH-1];
      end

      if (div_by_zero) begin
        done     <= 1'b1;
        div_zero <= 1'b1;
      end

      if (state == ST_MULT_RUN) begin
        acc  <= booth_p;
        qr   <= booth_q;
        q_m1 <= qr[0];
        cnt  <= cnt + 1'b1;
      end

      if (state == ST_DIV_RUN) begin
        acc <= div_r;
        qr  <= div_q;
        cnt <= cnt + 1'b1;
      end

      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
        if (state == ST_MULT_RUN) begin
          hi <= booth_p;
          lo <= booth_q;
        end else begin
          hi <= r_fix;
          lo <= q_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit. Reference results
// come from plain 64-bit signed arithmetic (product, truncating / and %).
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_start, div_start;
  logic [31:0] a_in, b_in;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [63:0] last_res = '0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .mult_start(mult_start),
    .div_start (div_start),
    .a_in      (a_in),
    .b_in      (b_in),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = sa * sb;
    return p;
  endfunction

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request before a rising edge; returns #1 after that edge (E0).
  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mult_start = m;
    div_start  = d;
    a_in       = a;
    b_in       = b;
    @(posedge clk);
    #1;
  endtask

  // Drop the request, scramble operands, and count edges until done (bounded).
  task automatic finish_op(output int lat, output bit busy_gap);
    @(negedge clk);
    mult_start = 1'b0;
    div_start  = 1'b0;
    a_in       = $urandom;
    b_in       = $urandom;
    lat        = 0;
    busy_gap   = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_gap = 1'b1;
    end
  endtask

  task automatic run_op(input string tag, input bit m, input bit d,
                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int          lat;
    bit          gap;
    exp = m ? ref_mult(a, b) : ref_div(a, b);
    start_op(m, d, a, b);
    chk($sformatf("%s.busy_E0", tag), 64'(busy), 64'd1);
    chk($sformatf("%s.dz_E0", tag), 64'(div_zero), 64'd0);
    finish_op(lat, gap);
    chk($sformatf("%s.latency", tag), 64'(lat), 64'd32);
    chk($sformatf("%s.busy_gap", tag), 64'(gap), 64'd0);
    chk($sformatf("%s.busy_E32", tag), 64'(busy), 64'd0);
    chk($sformatf("%s.hilo", tag), {hi, lo}, exp);
    @(posedge clk);
    #1;
    chk($sformatf("%s.done_E33", tag), 64'(done), 64'd0);
    last_res = exp;
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          lat;

    reset      = 1'b1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a_in       = '0;
    b_in       = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.hilo", {hi, lo}, 64'd0);
    chk("reset.flags", {61'd0, busy, done, div_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed arithmetic cases
    run_op("mul_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    chk("mul_7x-3.const", last_res, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mul_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    chk("mul_min_min.const", {hi, lo}, 64'h4000_0000_0000_0000);
    run_op("mul_m1_m1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mul_m1_m1.const", {hi, lo}, 64'h0000_0000_0000_0001);
    run_op("div_-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    chk("div_-7/2.const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_7/-2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
    chk("div_7/-2.const", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

    // Divide by zero: immediate done, no busy, hi/lo untouched
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    chk("dz.done_E0", 64'(done), 64'd1);
    chk("dz.flag_E0", 64'(div_zero), 64'd1);
    chk("dz.busy_E0", 64'(busy), 64'd0);
    chk("dz.hilo", {hi, lo}, last_res);
    @(negedge clk);
    div_start = 1'b0;
    @(posedge clk);
    #1;
    chk("dz.done_E1", 64'(done), 64'd0);
    chk("dz.flag_held", 64'(div_zero), 64'd1);
    run_op("mul_after_dz", 1'b1, 1'b0, 32'h0001_2345, 32'hFFFF_0100);

    run_op("div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_min/-1.const", {hi, lo}, 64'h0000_0000_8000_0000);
    chk("div_min/-1.dz", 64'(div_zero), 64'd0);

    // Both starts: multiply wins
    run_op("both_starts", 1'b1, 1'b1, 32'hFFFF_FF00, 32'd300);

    // Start requests mid-operation are ignored and not queued
    start_op(1'b1, 1'b0, 32'd1234, 32'hFFFF_FFF6);
    @(negedge clk);
    mult_start = 1'b0;
    a_in       = $urandom;
    b_in       = $urandom;
    repeat (4) @(posedge clk);
    @(negedge clk);
    mult_start = 1'b1;
    div_start  = 1'b1;
    b_in       = '0;
    @(posedge clk);
    @(negedge clk);
    mult_start = 1'b0;
    div_start  = 1'b0;
    lat = 0;
    for (int k = 6; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("ignore.latency", 64'(lat), 64'd32);
    chk("ignore.hilo", {hi, lo}, ref_mult(32'd1234, 32'hFFFF_FFF6));
    chk("ignore.dz", 64'(div_zero), 64'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("ignore.no_queue", 64'(busy), 64'd0);

    // Reset during an operation at E10
    start_op(1'b1, 1'b0, 32'h7777_0001, 32'h0000_0333);
    @(negedge clk);
    mult_start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid.hilo", {hi, lo}, 64'd0);
    chk("rst_mid.flags", {61'd0, busy, done, div_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("mul_3x4", 1'b1, 1'b0, 32'd3, 32'd4);
    chk("mul_3x4.lo", 64'(lo), 64'd12);

    // Randomized operands against the arithmetic reference
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op("rand_mul", 1'b1, 1'b0, ra, rb);
    end
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      if (i % 2 == 0) rb = $urandom;
      else            rb = $urandom_range(1, 1000);
      if (i % 3 == 0) rb = 32'd0 - rb;
      if (rb == 32'd0) rb = 32'd1;
      run_op("rand_div", 1'b0, 1'b1, ra, rb);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
